// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, valid while count != 0.
module sync_fifo
    import riscv_pkg::*;
#(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with prefetch buffer and branch/jump redirect flush.
// Optional same-cycle response bypass to the decoder: define FETCHQ_BYPASS_EN.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  br_true,
    input  logic [ADDR_WIDTH-1:0] br_addr,
    input  logic                  j_true,
    input  logic [ADDR_WIDTH-1:0] j_addr,
    output logic                  imem_re,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic                  issue;
    logic                  has_space;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redir_tgt;
    logic [ADDR_WIDTH-1:0] fetch_pc_p0;
    logic                  req_vld_p1;
    logic [ADDR_WIDTH-1:0] req_pc_p1;
    logic [ADDR_WIDTH-1:0] last_pc;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  pop_acc;

    assign redirect  = j_true | br_true;
    assign redir_tgt = j_true ? j_addr : br_addr;

    // Credit counts buffered plus in-flight words; a same-cycle pop earns nothing.
    assign has_space = (fifo_cnt + CNT_W'(req_vld_p1)) < CNT_W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                issue = fetch_en & has_space & ~redirect & ~rst;
                if (fetch_en) state_nxt = RUN;
            end
            RUN: begin
                issue = fetch_en & has_space & ~redirect & ~rst;
                if (!fetch_en && !req_vld_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_re   = issue;
    assign imem_addr = fetch_pc_p0;

    // Stage p0 -> p1: request issued, response returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_p0 <= RESET_PC;
            req_vld_p1  <= 1'b0;
        end else begin
            req_vld_p1 <= issue;
            if (redirect)   fetch_pc_p0 <= {redir_tgt[ADDR_WIDTH-1:2], 2'b00};
            else if (issue) fetch_pc_p0 <= fetch_pc_p0 + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_pc_p1 <= fetch_pc_p0;
    end

    assign fifo_empty = (fifo_cnt == '0);

`ifdef FETCHQ_BYPASS_EN
    logic bypass;

    // An empty buffer forwards the arriving word straight to the decoder.
    assign bypass      = fifo_empty & req_vld_p1;
    assign instr_valid = ~fifo_empty | req_vld_p1;
    assign instr       = ~fifo_empty ? fifo_head[ENTRY_W-1:ADDR_WIDTH]
                       : (bypass ? imem_rdata : DATA_WIDTH'(INSTR_NOP));
    assign pc_out      = ~fifo_empty ? fifo_head[ADDR_WIDTH-1:0]
                       : (bypass ? req_pc_p1 : last_pc);
    assign pop_acc     = instr_valid & instr_ready & ~redirect;
    assign fifo_push   = req_vld_p1 & ~redirect & ~(bypass & instr_ready);
    assign fifo_pop    = pop_acc & ~fifo_empty;
`else
    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_empty ? DATA_WIDTH'(INSTR_NOP) : fifo_head[ENTRY_W-1:ADDR_WIDTH];
    assign pc_out      = fifo_empty ? last_pc : fifo_head[ADDR_WIDTH-1:0];
    assign pop_acc     = instr_valid & instr_ready & ~redirect;
    assign fifo_push   = req_vld_p1 & ~redirect;
    assign fifo_pop    = pop_acc;
`endif

    // Stage p1 -> buffer: a response arriving during a redirect is discarded.
    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   ({imem_rdata, req_pc_p1}),
        .count (fifo_cnt),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_pc <= RESET_PC;
        else if (pop_acc) last_pc <= pc_out;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven and scoreboard bench for fetch_queue (default build, no bypass).
module tb_fetch_queue;

    localparam int          DW = 32;
    localparam int          AW = 16;
    localparam logic [15:0] RPC = 16'h0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          br_true;
    logic [AW-1:0] br_addr;
    logic          j_true;
    logic [AW-1:0] j_addr;
    logic          imem_re;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] pc_out;

    always #5 clk = ~clk;

    fetch_queue #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (4),
        .RESET_PC   (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .br_true     (br_true),
        .br_addr     (br_addr),
        .j_true      (j_true),
        .j_addr      (j_addr),
        .imem_re     (imem_re),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_out      (pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Fixed one-cycle-latency memory; garbage when no read was issued.
    always @(posedge clk) imem_rdata <= imem_re ? mem_word(imem_addr) : 32'hDEADBEEF;

    typedef struct {
        logic        fe, rdy, br;
        logic [15:0] ba;
        logic        j;
        logic [15:0] ja;
        logic        ere;
        logic [15:0] eaddr;
        logic        evld;
        logic        chkpc;
        logic [15:0] epc;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] model_pc = RPC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic fe, input logic rdy, input logic br, input logic [15:0] ba,
                                input logic j, input logic [15:0] ja, input logic ere, input logic [15:0] eaddr,
                                input logic evld, input logic chkpc, input logic [15:0] epc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.br = br; v.ba = ba; v.j = j; v.ja = ja;
        v.ere = ere; v.eaddr = eaddr; v.evld = evld; v.chkpc = chkpc; v.epc = epc;
        vecs.push_back(v);
    endfunction

    initial begin
        int nv;
        sb_t e;
        rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
        br_true = 1'b0; br_addr = '0; j_true = 1'b0; j_addr = '0;

        //   fe rdy br  ba       j  ja       re addr     vld cpc pc
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000); // c0
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 1, 0, 16'h0004);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 1, 0, 16'h0008); // c4 stall
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0014, 1, 0, 16'h0008);
        for (int k = 6; k <= 13; k++)
            add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0008);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0008); // c14 release
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0018, 1, 0, 16'h000C);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h001C, 1, 0, 16'h0010);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 1, 0, 16'h0014);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0024, 1, 0, 16'h0018);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0028, 1, 0, 16'h001C);
        add(1, 0, 1, 16'h0102, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h001C); // c20 branch
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h0018);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0104, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0108, 1, 0, 16'h0100);
        add(1, 1, 1, 16'h0040, 1, 16'h0080, 0, 16'h0000, 1, 0, 16'h0104); // c24 br+j
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0084, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0088, 1, 0, 16'h0080);
        add(1, 1, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0000, 1, 0, 16'h0084); // c28 jump to top
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFC, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'hFFFC);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 0, 16'h0000);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0004); // c33
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0004);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 1, 0, 16'h0004);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 1, 0, 16'h0004); // c36: 3 buf + 1 in flight

        // Scoreboard: expected words are queued at issue and checked at acceptance.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    sb.delete();
                    model_pc = RPC;
                end else begin
                    if (instr_valid && instr_ready && !(br_true || j_true)) begin
                        if (sb.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL sb_unexpected: got pc %h expected no instruction", pc_out);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_pc", 32'(pc_out), 32'(e.pc));
                            chk("sb_instr", instr, e.data);
                        end
                    end
                    if (br_true || j_true) begin
                        sb.delete();
                        model_pc = (j_true ? j_addr : br_addr) & 16'hFFFC;
                        chk("sb_redir_no_re", 32'(imem_re), 32'd0);
                    end else if (imem_re) begin
                        chk("sb_addr", 32'(imem_addr), 32'(model_pc));
                        e.pc = model_pc;
                        e.data = mem_word(model_pc);
                        sb.push_back(e);
                        model_pc = model_pc + 16'd4;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_re", 32'(imem_re), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RPC));
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", 32'(pc_out), 32'(RPC));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            fetch_en = vecs[i].fe; instr_ready = vecs[i].rdy;
            br_true = vecs[i].br; br_addr = vecs[i].ba;
            j_true = vecs[i].j; j_addr = vecs[i].ja;
            @(negedge clk);
            chk($sformatf("c%0d_re", i), 32'(imem_re), 32'(vecs[i].ere));
            if (vecs[i].ere) chk($sformatf("c%0d_addr", i), 32'(imem_addr), 32'(vecs[i].eaddr));
            chk($sformatf("c%0d_valid", i), 32'(instr_valid), 32'(vecs[i].evld));
            if (vecs[i].evld || vecs[i].chkpc) chk($sformatf("c%0d_pc", i), 32'(pc_out), 32'(vecs[i].epc));
            if (!vecs[i].evld) chk($sformatf("c%0d_nop", i), instr, NOP);
        end

        // Asynchronous reset in the middle of a cycle with a full pipeline.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_re", 32'(imem_re), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'(RPC));
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_pc", 32'(pc_out), 32'(RPC));
        fetch_en = 1'b1; instr_ready = 1'b1;
        #1 chk("mid_rst_re_gated", 32'(imem_re), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        nv = 0;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            if (k < 2) chk($sformatf("post_rst_c%0d_valid", k), 32'(instr_valid), 32'd0);
            if (k == 2) begin
                chk("post_rst_first_valid", 32'(instr_valid), 32'd1);
                chk("post_rst_first_pc", 32'(pc_out), 32'(RPC));
            end
            if (instr_valid) nv++;
        end
        chk("throughput", 32'(nv), 32'd20);

        @(posedge clk);
        #1 fetch_en = 1'b0; instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
